// File: rtl/rbg_pkg.sv
// rbg_pkg: shared types and constants for restricted_bag_gen.
// Holds the FSM state enum, the Galois LFSR tap-mask table indexed by
// LFSR width (16..32), and the head-bias comparison width PROB_SHIFT.
package rbg_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    PICK  = 2'd1,
    EMIT  = 2'd2,
    TAIL  = 2'd3
  } rbg_state_e;

  // prob is a numerator in 64ths, so the head decision compares 6 LFSR bits.
  localparam int PROB_SHIFT = 6;

  localparam int LFSR_W_MIN = 16;
  localparam int LFSR_W_MAX = 32;

  // Right-shifting Galois tap masks for maximal-length sequences.
  localparam logic [31:0] LFSR_TAPS [LFSR_W_MIN:LFSR_W_MAX] = '{
    32'h0000B400,  // 16
    32'h00012000,  // 17
    32'h00020400,  // 18
    32'h00072000,  // 19
    32'h00090000,  // 20
    32'h00140000,  // 21
    32'h00300000,  // 22
    32'h00420000,  // 23
    32'h00E10000,  // 24
    32'h01200000,  // 25
    32'h02000023,  // 26
    32'h04000013,  // 27
    32'h09000000,  // 28
    32'h14000000,  // 29
    32'h20000029,  // 30
    32'h48000000,  // 31
    32'h80200003   // 32
  };

endpackage

// File: rtl/rbg_lfsr.sv
// rbg_lfsr: free-running right-shift Galois LFSR with synchronous seed load.
// Ports: clk/rst (async active-high, resets to 1), load_i + seed_i load a
// seed (all-zero seed is replaced by 1 so the register never locks up), lfsr_o state.
module rbg_lfsr
  import rbg_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] seed_i,
  output logic [W-1:0] lfsr_o
);

  localparam logic [W-1:0] TAPS = W'(LFSR_TAPS[W]);

  logic [W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[W-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    if (load_i) begin
      lfsr_d = (seed_i == '0) ? W'(1) : seed_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= W'(1);
    else     lfsr_q <= lfsr_d;
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/restricted_bag_gen.sv
// restricted_bag_gen: emits bags (permutations of 0..NUM_SYM-1) where one
// restricted symbol is either forced first (with probability prob/64) or held back
// to be the last symbol of the bag.
// Ports: clk, rst (async active-high); seedLoad/seed reseed the LFSR and restart;
// restrected/prob sampled once per bag; outValid/outReady handshake carrying
// outSym, with bagStart marking the first symbol of each bag.
// Option: define RESTRICTED_BAG_GEN_NOREPEAT_EN to keep the first picked symbol
// of a bag from repeating the last symbol delivered before it.
module restricted_bag_gen
  import rbg_pkg::*;
#(
  parameter  int NUM_SYM   = 4,
  parameter  int LFSR_W    = 16,
  parameter  int MAX_TRIES = 7,
  localparam int SYM_W     = (NUM_SYM > 2) ? $clog2(NUM_SYM) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              seedLoad,
  input  logic [LFSR_W-1:0] seed,
  input  logic [SYM_W-1:0]  restrected,
  input  logic [2:0]        prob,
  input  logic              outReady,
  output logic              outValid,
  output logic [SYM_W-1:0]  outSym,
  output logic              bagStart
);

  localparam int TRY_W = $clog2(MAX_TRIES + 2);
  localparam logic [NUM_SYM-1:0] ALL_ONES = {NUM_SYM{1'b1}};

  rbg_state_e         state_q, state_d;
  logic [NUM_SYM-1:0] mask_q, mask_d;
  logic [SYM_W-1:0]   rsym_q, rsym_d;
  logic [SYM_W-1:0]   sym_q, sym_d;
  logic               head_q, head_d;
  logic               first_q, first_d;
  logic [TRY_W-1:0]   tries_q, tries_d;

  logic [LFSR_W-1:0]  lfsr;
  logic               unused_lfsr_hi;

  logic [NUM_SYM-1:0] rsym_oh, sym_oh, defer_oh;
  logic [NUM_SYM-1:0] base_elig, pick_elig, mask_after, rest_after;
  logic [SYM_W-1:0]   cand, low_sym;
  logic               cand_ok, xfer, head_now;

  rbg_lfsr #(.W(LFSR_W)) u_lfsr (
    .clk    (clk),
    .rst    (rst),
    .load_i (seedLoad),
    .seed_i (seed),
    .lfsr_o (lfsr)
  );

  assign unused_lfsr_hi = ^lfsr[LFSR_W-1:PROB_SHIFT];

  assign outValid = (state_q == EMIT) || (state_q == TAIL);
  assign outSym   = sym_q;
  assign bagStart = outValid && first_q;
  assign xfer     = outValid && outReady;

  always_comb begin
    rsym_oh = '0;
    sym_oh  = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (rsym_q == SYM_W'(i)) rsym_oh[i] = 1'b1;
      if (sym_q == SYM_W'(i))  sym_oh[i]  = 1'b1;
    end
  end

  // A headed bag has already delivered its restricted symbol, so nothing is held back.
  assign defer_oh   = head_q ? '0 : rsym_oh;
  assign base_elig  = mask_q & ~defer_oh;
  assign mask_after = mask_q & ~sym_oh;
  assign rest_after = mask_after & ~defer_oh;

`ifdef RESTRICTED_BAG_GEN_NOREPEAT_EN
  logic [SYM_W-1:0]   last_q;
  logic               last_vld_q;
  logic [NUM_SYM-1:0] last_oh, nr_elig;

  always_comb begin
    last_oh = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (last_q == SYM_W'(i)) last_oh[i] = 1'b1;
    end
  end

  // first_q is still set only during the first pick of a non-headed bag.
  // If the exclusion would leave nothing eligible, the plain set is used instead.
  assign nr_elig   = base_elig & ~last_oh;
  assign pick_elig = (first_q && last_vld_q && (nr_elig != '0)) ? nr_elig : base_elig;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (xfer) begin
      last_q     <= sym_q;
      last_vld_q <= 1'b1;
    end
  end
`else
  assign pick_elig = base_elig;
`endif

  assign cand     = lfsr[SYM_W-1:0];
  assign head_now = lfsr[PROB_SHIFT-1:0] < {3'b000, prob};

  // Candidate check plus lowest-eligible priority encoder for the fallback pick.
  always_comb begin
    cand_ok = 1'b0;
    low_sym = '0;
    for (int i = NUM_SYM - 1; i >= 0; i--) begin
      if (pick_elig[i]) low_sym = SYM_W'(i);
      if (pick_elig[i] && (cand == SYM_W'(i))) cand_ok = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    rsym_d  = rsym_q;
    sym_d   = sym_q;
    head_d  = head_q;
    first_d = first_q;
    tries_d = tries_q;
    case (state_q)
      START: begin
        rsym_d  = restrected;
        head_d  = head_now;
        mask_d  = ALL_ONES;
        first_d = 1'b1;
        tries_d = '0;
        if (head_now) begin
          sym_d   = restrected;
          state_d = EMIT;
        end else begin
          state_d = PICK;
        end
      end
      PICK: begin
        if (cand_ok) begin
          sym_d   = cand;
          tries_d = '0;
          state_d = EMIT;
        end else if (tries_q == TRY_W'(MAX_TRIES)) begin
          sym_d   = low_sym;
          tries_d = '0;
          state_d = EMIT;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      EMIT, TAIL: begin
        if (xfer) begin
          mask_d  = mask_after;
          first_d = 1'b0;
          if (mask_after == '0) begin
            state_d = START;
          end else if (rest_after != '0) begin
            state_d = PICK;
          end else begin
            sym_d   = rsym_q;
            state_d = TAIL;
          end
        end
      end
      default: state_d = START;
    endcase
    // Reseeding wins over a simultaneous transfer; that symbol still counts as sent.
    if (seedLoad) begin
      state_d = START;
      mask_d  = ALL_ONES;
      first_d = 1'b0;
      tries_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= START;
      mask_q  <= ALL_ONES;
      rsym_q  <= '0;
      sym_q   <= '0;
      head_q  <= 1'b0;
      first_q <= 1'b0;
      tries_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      rsym_q  <= rsym_d;
      sym_q   <= sym_d;
      head_q  <= head_d;
      first_q <= first_d;
      tries_q <= tries_d;
    end
  end

endmodule

// File: tb/tb_restricted_bag_gen.sv
// tb_restricted_bag_gen: bag-level reference model for restricted_bag_gen.
// Checks permutations, restricted placement, handshake stability, reseed
// determinism, pick-time bound and reset behaviour under random stimulus.
module tb_restricted_bag_gen;

  localparam int NUM_SYM   = 4;
  localparam int LFSR_W    = 16;
  localparam int MAX_TRIES = 7;
  localparam int SYM_W     = 2;
  localparam int REC_N     = 40;

  logic              clk = 1'b0;
  logic              rst;
  logic              seedLoad;
  logic [LFSR_W-1:0] seed;
  logic [SYM_W-1:0]  restrected;
  logic [2:0]        prob;
  logic              outReady;
  logic              outValid;
  logic [SYM_W-1:0]  outSym;
  logic              bagStart;

  always #5 clk = ~clk;

  restricted_bag_gen #(
    .NUM_SYM   (NUM_SYM),
    .LFSR_W    (LFSR_W),
    .MAX_TRIES (MAX_TRIES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .seedLoad   (seedLoad),
    .seed       (seed),
    .restrected (restrected),
    .prob       (prob),
    .outReady   (outReady),
    .outValid   (outValid),
    .outSym     (outSym),
    .bagStart   (bagStart)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Model state: symbols of the bag in progress and what that bag latched.
  int bag_q[$];
  int bag_r, bag_p;
  int last_sym = -1;
  bit bag_done;
  int n_bags = 0;
  int n_heads = 0;
  bit prev_vld, prev_rdy, prev_ld;
  int prev_sym, prev_bs;
  bit wait_first;
  int since_ld;
  int idle_run;
  bit idle_clean;
  int rec_q[$];
  int ref_q[$];

  task automatic transfer(input int s, input int bs);
    bit dup;
    chk("bagStart", bs, int'(bag_q.size() == 0));
    chk("sym_range", int'(s < NUM_SYM), 1);
    dup = 1'b0;
    foreach (bag_q[i]) if (bag_q[i] == s) dup = 1'b1;
    chk("no_dup", int'(dup), 0);
`ifdef RESTRICTED_BAG_GEN_NOREPEAT_EN
    if (bag_q.size() == 0 && last_sym >= 0 && s != bag_r)
      chk("norepeat", int'(s != last_sym), 1);
`endif
    last_sym = s;
    if (rec_q.size() < REC_N) rec_q.push_back(s * 2 + bs);
    bag_q.push_back(s);
    if (bag_q.size() == NUM_SYM) begin
      if (bag_p == 0) begin
        chk("restricted_last", bag_q[NUM_SYM-1], bag_r);
      end else begin
        chk("restricted_head_or_last",
            int'(bag_q[0] == bag_r || bag_q[NUM_SYM-1] == bag_r), 1);
        if (bag_q[0] == bag_r) n_heads++;
      end
      n_bags++;
      bag_done = 1'b1;
      bag_q.delete();
    end
  endtask

  // Called at a negedge once the inputs for the coming posedge are driven.
  task automatic cycle();
    if (prev_vld && !prev_rdy && !prev_ld) begin
      chk("stall_valid", int'(outValid), 1);
      chk("stall_sym", int'(outSym), prev_sym);
      chk("stall_bagStart", int'(bagStart), prev_bs);
    end
    if (wait_first && outValid) begin
      chk("first_valid_latency", int'(since_ld >= 2), 1);
      wait_first = 1'b0;
    end
    if (outValid) begin
      if (idle_clean) chk("pick_bound", int'(idle_run <= MAX_TRIES + 2), 1);
      idle_run   = 0;
      idle_clean = 1'b1;
    end else begin
      idle_run++;
    end
    if (outValid && outReady) transfer(int'(outSym), int'(bagStart));
    prev_vld = outValid;
    prev_rdy = outReady;
    prev_ld  = seedLoad;
    prev_sym = int'(outSym);
    prev_bs  = int'(bagStart);
    if (seedLoad) begin
      bag_q.delete();
      wait_first = 1'b1;
      since_ld   = 0;
      idle_clean = 1'b0;
      idle_run   = 0;
    end
    @(negedge clk);
    since_ld++;
  endtask

  // Runs until nb more bags complete; ends on a bag boundary.
  task automatic run_bags(input int nb, input int rdy_pct, input int p, input bit vary);
    int target = n_bags + nb;
    int budget = nb * NUM_SYM * 40 + 100;
    bag_p    = p;
    prob     = 3'(p);
    bag_done = 1'b1;
    while (n_bags < target && budget > 0) begin
      if (vary) begin
        if (bag_done) begin
          bag_r    = $urandom_range(0, NUM_SYM - 1);
          bag_done = 1'b0;
        end
        // Mid-bag the inputs carry junk; the latched values must rule.
        if (bag_q.size() >= 1 && bag_q.size() <= NUM_SYM - 2) begin
          restrected = SYM_W'($urandom_range(0, NUM_SYM - 1));
          prob       = 3'($urandom_range(0, 7));
        end else begin
          restrected = SYM_W'(bag_r);
          prob       = 3'(bag_p);
        end
      end
      outReady = ($urandom_range(0, 99) < rdy_pct);
      cycle();
      budget--;
    end
    outReady = 1'b1;
    chk("run_complete", int'(n_bags >= target), 1);
  endtask

  task automatic wait_mid(input int sz);
    int b = 200;
    outReady = 1'b1;
    while (!(outValid && bag_q.size() == sz) && b > 0) begin
      cycle();
      b--;
    end
    chk("wait_mid", int'(outValid && bag_q.size() == sz), 1);
  endtask

  task automatic load_seed(input logic [LFSR_W-1:0] s);
    seed     = s;
    seedLoad = 1'b1;
    cycle();
    seedLoad = 1'b0;
    rec_q.delete();
  endtask

  task automatic compare_rec(input string tag);
    chk({tag, "_len"}, rec_q.size(), REC_N);
    for (int i = 0; i < REC_N && i < rec_q.size() && i < ref_q.size(); i++)
      chk(tag, rec_q[i], ref_q[i]);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    #1;
    chk("reset_valid", int'(outValid), 0);
    chk("reset_sym", int'(outSym), 0);
    chk("reset_bagStart", int'(bagStart), 0);
    repeat (n) @(negedge clk);
    rst        = 1'b0;
    bag_q.delete();
    last_sym   = -1;
    prev_ld    = 1'b1;
    wait_first = 1'b0;
    idle_clean = 1'b0;
    idle_run   = 0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b0, pm;
    seedLoad   = 1'b0;
    seed       = '0;
    restrected = 2'd2;
    prob       = 3'd0;
    outReady   = 1'b1;
    bag_r      = 2;
    bag_p      = 0;
    @(negedge clk);
    do_reset(3);

    // Fixed restricted symbol, no head bias, always ready.
    load_seed(16'hACE1);
    run_bags(300, 100, 0, 1'b0);
    ref_q = rec_q;

    // Consumer stall mid-bag.
    wait_mid(2);
    outReady = 1'b0;
    repeat (20) cycle();
    outReady = 1'b1;
    run_bags(5, 100, 0, 1'b0);

    // Same seed, same inputs: same stream.
    load_seed(16'hACE1);
    run_bags(20, 100, 0, 1'b0);
    compare_rec("seed_repeat");

    // Zero seed during a transfer behaves like seed 1.
    wait_mid(1);
    load_seed('0);
    chk("load_drops_valid", int'(outValid), 0);
    run_bags(20, 100, 0, 1'b0);
    ref_q = rec_q;
    load_seed(16'h0001);
    run_bags(20, 100, 0, 1'b0);
    compare_rec("zero_seed");

    // Reset in the middle of a bag, then randomised phases.
    wait_mid(2);
    do_reset(2);
    run_bags(300, 70, 0, 1'b1);
    run_bags(300, 80, 4, 1'b1);

    // Head-bias rate with prob=7.
    bag_r      = 0;
    restrected = 2'd0;
    n_heads    = 0;
    b0         = n_bags;
    run_bags(1200, 70, 7, 1'b0);
    pm = (n_heads * 1000) / ((n_bags - b0) > 0 ? (n_bags - b0) : 1);
    chk("head_rate_permille_in_band", int'(pm >= 60 && pm <= 160), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
